// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction sequencer driving PC, IR, data memory, register file and ALU
module control_fsm (
   input  logic        Clock,
   input  logic        clr,
   input  logic [15:0] IR,
   output logic        PC_clr,
   output logic        PC_up,
   output logic        IR_ld,
   output logic [7:0]  D_addr,
   output logic        D_wr,
   output logic        RF_s,
   output logic [3:0]  RF_W_addr,
   output logic        RF_W_wr,
   output logic [3:0]  RF_Ra_addr,
   output logic        RF_Ra_rd,
   output logic [3:0]  RF_Rb_addr,
   output logic        RF_Rb_rd,
   output logic [2:0]  ALU_s0,
   output logic [3:0]  CurrentState,
   output logic [3:0]  NextState
);
   typedef enum logic [3:0] {
      INIT   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      NOOP   = 4'd3,
      LOAD_A = 4'd4,
      LOAD_B = 4'd5,
      STORE  = 4'd6,
      ADD    = 4'd7,
      SUB    = 4'd8,
      HALT   = 4'd9
   } state_t;

   state_t state, next;

   assign CurrentState = state;
   assign NextState    = next;

   // state register; clr overrides everything, including Halt and mid-instruction states
   always_ff @(posedge Clock) begin
      if (clr) state <= INIT;
      else     state <= next;
   end

   // next-state logic; Decode dispatches on the opcode, unknown opcodes fall back to NoOp
   always_comb begin
      next = INIT;
      case (state)
         INIT:   next = FETCH;
         FETCH:  next = DECODE;
         DECODE:
            case (IR[15:12])
               4'h1:    next = STORE;
               4'h2:    next = LOAD_A;
               4'h3:    next = ADD;
               4'h4:    next = SUB;
               4'h5:    next = HALT;
               default: next = NOOP;
            endcase
         LOAD_A: next = LOAD_B;
         HALT:   next = HALT;
         NOOP, LOAD_B, STORE, ADD, SUB: next = FETCH;
         default: next = INIT;
      endcase
   end

   // control outputs depend only on state and IR; everything idles at zero by default
   always_comb begin
      PC_clr     = 1'b0;
      PC_up      = 1'b0;
      IR_ld      = 1'b0;
      D_addr     = 8'd0;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = 4'd0;
      RF_W_wr    = 1'b0;
      RF_Ra_addr = 4'd0;
      RF_Ra_rd   = 1'b0;
      RF_Rb_addr = 4'd0;
      RF_Rb_rd   = 1'b0;
      ALU_s0     = 3'd0;
      case (state)
         INIT:  PC_clr = 1'b1;
         FETCH: begin
            IR_ld = 1'b1;
            PC_up = 1'b1;
         end
         LOAD_A, LOAD_B: begin
            D_addr    = IR[11:4];
            RF_s      = 1'b1;
            RF_W_addr = IR[3:0];
            RF_W_wr   = (state == LOAD_B);
         end
         STORE: begin
            D_addr     = IR[7:0];
            D_wr       = 1'b1;
            RF_Ra_addr = IR[11:8];
            RF_Ra_rd   = 1'b1;
         end
         ADD, SUB: begin
            RF_Ra_addr = IR[11:8];
            RF_Ra_rd   = 1'b1;
            RF_Rb_addr = IR[7:4];
            RF_Rb_rd   = 1'b1;
            RF_W_addr  = IR[3:0];
            RF_W_wr    = 1'b1;
            ALU_s0     = (state == ADD) ? 3'd1 : 3'd2;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed vector table plus randomized instruction stream against an instruction-level model
module tb_control_fsm;
   logic        Clock = 1'b0;
   logic        clr = 1'b1;
   logic [15:0] IR = 16'h0000;
   logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_wr, RF_Ra_rd, RF_Rb_rd;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, CurrentState, NextState;
   logic [2:0]  ALU_s0;

   typedef struct packed {
      logic [3:0] cs;
      logic [3:0] ns;
      logic       pc_clr;
      logic       pc_up;
      logic       ir_ld;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] w_addr;
      logic       w_wr;
      logic [3:0] ra;
      logic       ra_rd;
      logic [3:0] rb;
      logic       rb_rd;
      logic [2:0] alu;
   } exp_t;

   typedef struct packed {
      logic        clr;
      logic [15:0] ir;
      exp_t        e;
   } vec_t;

   exp_t act;
   vec_t vecs[$];
   exp_t tq[$];
   int   checks = 0;
   int   errors = 0;

   control_fsm dut (
      .Clock(Clock), .clr(clr), .IR(IR),
      .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
      .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
      .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
      .RF_Ra_addr(RF_Ra_addr), .RF_Ra_rd(RF_Ra_rd),
      .RF_Rb_addr(RF_Rb_addr), .RF_Rb_rd(RF_Rb_rd),
      .ALU_s0(ALU_s0), .CurrentState(CurrentState), .NextState(NextState)
   );

   always #5 Clock = ~Clock;

   assign act = {CurrentState, NextState, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
                 RF_W_addr, RF_W_wr, RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd, ALU_s0};

   function automatic exp_t o(input logic [3:0] cs, ns, input logic pcc, pcu, irl,
                              input logic [7:0] da, input logic dw, rs, input logic [3:0] wa,
                              input logic ww, input logic [3:0] ra, input logic rr,
                              input logic [3:0] rb, input logic br, input logic [2:0] al);
      return {cs, ns, pcc, pcu, irl, da, dw, rs, wa, ww, ra, rr, rb, br, al};
   endfunction

   function automatic exp_t idle(input logic [3:0] cs, ns);
      return o(cs, ns, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 3'd0);
   endfunction

   function automatic void add(input logic c, input logic [15:0] ir, input exp_t e);
      vecs.push_back({c, ir, e});
   endfunction

   // instruction-level model: the per-cycle output trace one instruction produces, starting at Fetch
   function automatic void build(input logic [15:0] ir);
      tq = {};
      tq.push_back(o(1, 2, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 3'd0));
      case (ir[15:12])
         4'h1: begin
            tq.push_back(idle(2, 6));
            tq.push_back(o(6, 1, 0, 0, 0, ir[7:0], 1, 0, 4'h0, 0, ir[11:8], 1, 4'h0, 0, 3'd0));
         end
         4'h2: begin
            tq.push_back(idle(2, 4));
            tq.push_back(o(4, 5, 0, 0, 0, ir[11:4], 0, 1, ir[3:0], 0, 4'h0, 0, 4'h0, 0, 3'd0));
            tq.push_back(o(5, 1, 0, 0, 0, ir[11:4], 0, 1, ir[3:0], 1, 4'h0, 0, 4'h0, 0, 3'd0));
         end
         4'h3, 4'h4: begin
            tq.push_back(idle(2, ir[15:12] == 4'h3 ? 4'd7 : 4'd8));
            tq.push_back(o(ir[15:12] == 4'h3 ? 4'd7 : 4'd8, 1, 0, 0, 0, 8'h00, 0, 0, ir[3:0], 1,
                           ir[11:8], 1, ir[7:4], 1, ir[15:12] == 4'h3 ? 3'd1 : 3'd2));
         end
         default: begin
            tq.push_back(idle(2, 3));
            tq.push_back(idle(3, 1));
         end
      endcase
   endfunction

   task automatic chk(input exp_t e, input string n);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got state=%0d next=%0d outs=%h, expected state=%0d next=%0d outs=%h",
                  n, act.cs, act.ns, act[30:0], e.cs, e.ns, e[30:0]);
      end
   endtask

   task automatic apply(input logic c, input logic [15:0] ir, input exp_t e, input string n);
      clr = c;
      IR  = ir;
      @(negedge Clock);
      chk(e, n);
   endtask

   initial begin
      exp_t init_e, fetch_e;
      init_e  = o(0, 1, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 3'd0);
      fetch_e = o(1, 2, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 3'd0);
      add(1, 16'h0000, init_e);
      add(1, 16'h0000, init_e);
      add(0, 16'h0000, fetch_e);
      add(0, 16'h0000, idle(2, 3));
      add(0, 16'h0000, idle(3, 1));
      add(0, 16'h2A53, fetch_e);
      add(0, 16'h2A53, idle(2, 4));
      add(0, 16'h2A53, o(4, 5, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 0, 4'h0, 0, 4'h0, 0, 3'd0));
      add(0, 16'h2A53, o(5, 1, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 1, 4'h0, 0, 4'h0, 0, 3'd0));
      add(0, 16'h1712, fetch_e);
      add(0, 16'h1712, idle(2, 6));
      add(0, 16'h1712, o(6, 1, 0, 0, 0, 8'h12, 1, 0, 4'h0, 0, 4'h7, 1, 4'h0, 0, 3'd0));
      add(0, 16'h3123, fetch_e);
      add(0, 16'h3123, idle(2, 7));
      add(0, 16'h3123, o(7, 1, 0, 0, 0, 8'h00, 0, 0, 4'h3, 1, 4'h1, 1, 4'h2, 1, 3'd1));
      add(0, 16'h4123, fetch_e);
      add(0, 16'h4123, idle(2, 8));
      add(0, 16'h4123, o(8, 1, 0, 0, 0, 8'h00, 0, 0, 4'h3, 1, 4'h1, 1, 4'h2, 1, 3'd2));
      add(0, 16'hF000, fetch_e);
      add(0, 16'hF000, idle(2, 3));
      add(0, 16'hF000, idle(3, 1));
      add(0, 16'h2A53, fetch_e);
      add(0, 16'h2A53, idle(2, 4));
      add(0, 16'h2A53, o(4, 5, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 0, 4'h0, 0, 4'h0, 0, 3'd0));
      add(1, 16'h2A53, init_e);
      add(0, 16'h5000, fetch_e);
      add(0, 16'h5000, idle(2, 9));
      for (int i = 0; i < 10; i++) add(0, 16'h5000, idle(9, 9));
      add(1, 16'h5000, init_e);
      add(1, 16'h0000, init_e);
      foreach (vecs[i]) apply(vecs[i].clr, vecs[i].ir, vecs[i].e, $sformatf("vec%0d", i));
      for (int n = 0; n < 60; n++) begin
         logic [15:0] ir;
         int          k;
         ir = 16'($urandom);
         if (ir[15:12] == 4'h5) ir[15:12] = 4'hE;
         build(ir);
         k = ($urandom_range(0, 5) == 0) ? $urandom_range(1, tq.size() - 1) : -1;
         foreach (tq[i]) begin
            if (i == k) begin
               apply(1, ir, init_e, $sformatf("rand%0d_abort", n));
               break;
            end
            apply(0, ir, tq[i], $sformatf("rand%0d_cyc%0d", n, i));
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
